// File: rtl/coleco_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// coleco_ctrl_pkg
// Shared definitions for the SNES-pad to ColecoVision controller front-end:
//   - bit positions of the 12 buttons in the active-high button vector
//     (this is also the SNES serial shift order)
//   - keypad codes presented on P3..P0 in keypad mode (active low)
//   - pad reader FSM state encoding
//   - keypad priority encoder
// -----------------------------------------------------------------------------
package coleco_ctrl_pkg;

   localparam int unsigned NUM_BTN   = 12;
   localparam int unsigned NUM_BITS  = 16;   // 12 buttons + 4 ID bits

   localparam int unsigned BTN_B      = 0;
   localparam int unsigned BTN_Y      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;
   localparam int unsigned BTN_A      = 8;
   localparam int unsigned BTN_X      = 9;
   localparam int unsigned BTN_L      = 10;
   localparam int unsigned BTN_R      = 11;

   localparam logic [3:0] KP_NONE = 4'hF;
   localparam logic [3:0] KP_1    = 4'hD;
   localparam logic [3:0] KP_2    = 4'h7;
   localparam logic [3:0] KP_3    = 4'hC;
   localparam logic [3:0] KP_STAR = 4'h9;
   localparam logic [3:0] KP_HASH = 4'h6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } pad_state_e;

   // Only one keypad key can be shown at a time; the highest-priority
   // pressed source button wins.
   function automatic logic [3:0] kp_encode(input logic [NUM_BTN-1:0] btn);
      if (btn[BTN_SELECT])     return KP_STAR;
      else if (btn[BTN_START]) return KP_HASH;
      else if (btn[BTN_X])     return KP_1;
      else if (btn[BTN_L])     return KP_2;
      else if (btn[BTN_R])     return KP_3;
      else                     return KP_NONE;
   endfunction

endpackage

// File: rtl/snes_pad_reader.sv
// -----------------------------------------------------------------------------
// snes_pad_reader
// Periodically polls an SNES serial gamepad and holds the last committed
// snapshot of its 12 buttons.
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   o_snes_latch   pad latch, active high
//   o_snes_clk     pad shift clock, idles high
//   i_snes_data    pad serial data, active low
//   o_buttons      committed snapshot, active high (bit order from package)
//   o_snap_valid   one-clk pulse coincident with a new snapshot on o_buttons
// -----------------------------------------------------------------------------
module snes_pad_reader
   import coleco_ctrl_pkg::*;
#(
   parameter int unsigned LATCH_CYC = 43,
   parameter int unsigned HALF_CYC  = 21,
   parameter int unsigned POLL_CYC  = 59659
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_snes_latch,
   output logic               o_snes_clk,
   input  logic               i_snes_data,
   output logic [NUM_BTN-1:0] o_buttons,
   output logic               o_snap_valid
);

   localparam int unsigned POLL_W = ($clog2(POLL_CYC) > 0) ? $clog2(POLL_CYC) : 1;
   localparam int unsigned PH_MAX = (LATCH_CYC > 2 * HALF_CYC) ? LATCH_CYC : 2 * HALF_CYC;
   localparam int unsigned PH_W   = ($clog2(PH_MAX) > 0) ? $clog2(PH_MAX) : 1;

   pad_state_e          r_state,   w_state_nxt;
   logic [POLL_W-1:0]   r_poll;
   logic [PH_W-1:0]     r_ph,      w_ph_nxt;
   logic [3:0]          r_bit,     w_bit_nxt;
   logic                r_latch,   w_latch_nxt;
   logic                r_sclk,    w_sclk_nxt;
   logic [NUM_BITS-1:0] r_shift,   w_shift_nxt;
   logic [NUM_BTN-1:0]  r_buttons, w_buttons_nxt;
   logic                r_valid,   w_valid_nxt;
   logic                w_poll_wrap;

   // The poll counter runs freely through the whole poll, so the period is
   // measured start-to-start regardless of how long a poll takes.
   assign w_poll_wrap = (r_poll == POLL_W'(POLL_CYC - 1));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      w_state_nxt   = r_state;
      w_ph_nxt      = r_ph;
      w_bit_nxt     = r_bit;
      w_latch_nxt   = r_latch;
      w_sclk_nxt    = r_sclk;
      w_shift_nxt   = r_shift;
      w_buttons_nxt = r_buttons;
      w_valid_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_poll_wrap) begin
               w_state_nxt = ST_LATCH;
               w_latch_nxt = 1'b1;
               w_ph_nxt    = '0;
            end
         end

         ST_LATCH: begin
            if (r_ph == PH_W'(LATCH_CYC - 1)) begin
               w_state_nxt = ST_SHIFT;
               w_latch_nxt = 1'b0;
               w_ph_nxt    = '0;
               w_bit_nxt   = '0;
            end else begin
               w_ph_nxt = r_ph + PH_W'(1);
            end
         end

         // One bit = HALF_CYC high (sample on its last cycle) + HALF_CYC low.
         // The rising edge ending the low half starts the next bit's high half.
         ST_SHIFT: begin
            w_ph_nxt = r_ph + PH_W'(1);
            if (r_ph == PH_W'(HALF_CYC - 1)) begin
               w_shift_nxt[r_bit] = i_snes_data;
               w_sclk_nxt         = 1'b0;
            end else if (r_ph == PH_W'(2 * HALF_CYC - 1)) begin
               w_sclk_nxt = 1'b1;
               w_ph_nxt   = '0;
               w_bit_nxt  = r_bit + 4'd1;
               if (r_bit == 4'd15) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            // All-zero data (including the ID bits, which a real pad drives
            // high) means nothing is driving the line: report all released.
            w_buttons_nxt = (r_shift == '0) ? '0 : ~r_shift[NUM_BTN-1:0];
            w_valid_nxt   = 1'b1;
            w_state_nxt   = ST_IDLE;
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every register
   // samples the pre-edge values; the comb block above uses blocking ones.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_poll    <= '0;
         r_ph      <= '0;
         r_bit     <= '0;
         r_latch   <= 1'b0;
         r_sclk    <= 1'b1;
         // NOTE: the shift register is reset too, so a poll cut short by
         // rst can never leak partial bits into a later snapshot.
         r_shift   <= '0;
         r_buttons <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_poll    <= w_poll_wrap ? '0 : r_poll + POLL_W'(1);
         r_ph      <= w_ph_nxt;
         r_bit     <= w_bit_nxt;
         r_latch   <= w_latch_nxt;
         r_sclk    <= w_sclk_nxt;
         r_shift   <= w_shift_nxt;
         r_buttons <= w_buttons_nxt;
         r_valid   <= w_valid_nxt;
      end
   end

   assign o_snes_latch = r_latch;
   assign o_snes_clk   = r_sclk;
   assign o_buttons    = r_buttons;
   assign o_snap_valid = r_valid;

endmodule

// File: rtl/snes_coleco_ctrl.sv
// -----------------------------------------------------------------------------
// snes_coleco_ctrl
// One player's controller front-end: polls an SNES pad and drives the six
// active-low ColecoVision controller pins according to the glue's strobes.
//   clk            system clock (glue domain)
//   rst            synchronous, active-high reset
//   snes_latch     pad latch, active high
//   snes_clk       pad shift clock, idles high
//   snes_data      pad serial data, active low
//   strobe_fire_n  C1P7 strobe, low selects joystick pattern
//   strobe_arm_n   C1P4 strobe, low selects keypad pattern
//   pins_n         {P6,P5,P3,P2,P1,P0}, active low, registered
//   snap_valid     one-clk pulse when a new snapshot is committed
// Build option: define SNES_COLECO_TURBO_FIRE_EN to make Y an auto-repeat
// left fire that toggles every TURBO_POLLS snapshots.
// -----------------------------------------------------------------------------
module snes_coleco_ctrl
   import coleco_ctrl_pkg::*;
#(
   parameter int unsigned LATCH_CYC   = 43,
   parameter int unsigned HALF_CYC    = 21,
   parameter int unsigned POLL_CYC    = 59659
`ifdef SNES_COLECO_TURBO_FIRE_EN
   ,
   parameter int unsigned TURBO_POLLS = 4
`endif
) (
   input  logic       clk,
   input  logic       rst,
   output logic       snes_latch,
   output logic       snes_clk,
   input  logic       snes_data,
   input  logic       strobe_fire_n,
   input  logic       strobe_arm_n,
   output logic [5:0] pins_n,
   output logic       snap_valid
);

   logic [NUM_BTN-1:0] w_buttons;
   logic               w_snap_valid;
   logic               w_turbo_fire;
   logic               w_fire_left;
   logic [5:0]         w_joy_n;
   logic [5:0]         w_kp_n;
   logic [5:0]         w_pins_nxt;
   logic [5:0]         r_pins;

   snes_pad_reader #(
      .LATCH_CYC (LATCH_CYC),
      .HALF_CYC  (HALF_CYC),
      .POLL_CYC  (POLL_CYC)
   ) u_reader (
      .i_clk        (clk),
      .i_rst        (rst),
      .o_snes_latch (snes_latch),
      .o_snes_clk   (snes_clk),
      .i_snes_data  (snes_data),
      .o_buttons    (w_buttons),
      .o_snap_valid (w_snap_valid)
   );

`ifdef SNES_COLECO_TURBO_FIRE_EN
   localparam int unsigned TP_W = (TURBO_POLLS > 1) ? $clog2(TURBO_POLLS) : 1;

   logic [TP_W-1:0] r_turbo_cnt;
   logic            r_turbo_phase;

   // Advances once per committed snapshot while Y is held; the first
   // snapshot with Y pressed always fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_turbo_cnt   <= '0;
         r_turbo_phase <= 1'b0;
      end else if (w_snap_valid) begin
         if (w_buttons[BTN_Y]) begin
            if (r_turbo_cnt == TP_W'(TURBO_POLLS - 1)) begin
               r_turbo_cnt   <= '0;
               r_turbo_phase <= ~r_turbo_phase;
            end else begin
               r_turbo_cnt <= r_turbo_cnt + TP_W'(1);
            end
         end else begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b0;
         end
      end
   end

   assign w_turbo_fire = w_buttons[BTN_Y] & ~r_turbo_phase;
`else
   logic w_unused_y;
   assign w_unused_y   = w_buttons[BTN_Y];
   assign w_turbo_fire = 1'b0;
`endif

   assign w_fire_left = w_buttons[BTN_B] | w_turbo_fire;

   assign w_joy_n = {~w_fire_left, 1'b1,
                     ~w_buttons[BTN_LEFT], ~w_buttons[BTN_DOWN],
                     ~w_buttons[BTN_RIGHT], ~w_buttons[BTN_UP]};
   assign w_kp_n  = {~w_buttons[BTN_A], 1'b1, kp_encode(w_buttons)};

   // Both strobes low models the wired-low bus: either pattern pulls a pin low.
   always_comb begin
      w_pins_nxt = 6'h3F;
      case ({strobe_fire_n, strobe_arm_n})
         2'b01:   w_pins_nxt = w_joy_n;
         2'b10:   w_pins_nxt = w_kp_n;
         2'b00:   w_pins_nxt = w_joy_n & w_kp_n;
         default: w_pins_nxt = 6'h3F;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pins <= 6'h3F;
      end else begin
         r_pins <= w_pins_nxt;
      end
   end

   assign pins_n     = r_pins;
   assign snap_valid = w_snap_valid;

endmodule

// File: tb/tb_snes_coleco_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snes_coleco_ctrl
// Self-checking bench for snes_coleco_ctrl with a behavioural SNES pad and a
// pin-pattern reference model derived from the controller pin rules.
// -----------------------------------------------------------------------------
module tb_snes_coleco_ctrl;

   localparam int LATCH       = 3;
   localparam int HALF        = 2;
   localparam int POLL        = 200;
   localparam int TURBO_POLLS = 2;
`ifdef SNES_COLECO_TURBO_FIRE_EN
   localparam bit TURBO_ON = 1'b1;
`else
   localparam bit TURBO_ON = 1'b0;
`endif

   localparam int K_B = 0, K_Y = 1, K_SEL = 2, K_START = 3, K_UP = 4, K_DOWN = 5;
   localparam int K_LEFT = 6, K_RIGHT = 7, K_A = 8, K_X = 9, K_L = 10, K_R = 11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       snes_latch;
   logic       snes_clk;
   logic       snes_data;
   logic       strobe_fire_n = 1'b1;
   logic       strobe_arm_n  = 1'b1;
   logic [5:0] pins_n;
   logic       snap_valid;

   int checks   = 0;
   int failures = 0;

   // pad model state
   logic [11:0] pad_btn   = 12'h000;
   logic        pad_stuck = 1'b0;
   int          pad_idx   = 0;

   // reference model state
   logic [11:0] m_snap  = 12'h000;
   int          m_ny    = 0;
   bit          m_turbo = 1'b0;

   always #5 clk = ~clk;

   snes_coleco_ctrl #(
      .LATCH_CYC (LATCH),
      .HALF_CYC  (HALF),
      .POLL_CYC  (POLL)
`ifdef SNES_COLECO_TURBO_FIRE_EN
      ,
      .TURBO_POLLS (TURBO_POLLS)
`endif
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .snes_latch    (snes_latch),
      .snes_clk      (snes_clk),
      .snes_data     (snes_data),
      .strobe_fire_n (strobe_fire_n),
      .strobe_arm_n  (strobe_arm_n),
      .pins_n        (pins_n),
      .snap_valid    (snap_valid)
   );

   // SNES pad: latch reloads bit 0, each rising shift clock advances a bit.
   always @(posedge snes_latch) pad_idx <= 0;
   always @(posedge snes_clk) if (!snes_latch) pad_idx <= pad_idx + 1;

   always_comb begin
      if (pad_stuck)          snes_data = 1'b0;
      else if (pad_idx < 12)  snes_data = ~pad_btn[pad_idx[3:0]];
      else if (pad_idx < 16)  snes_data = 1'b1;
      else                    snes_data = 1'b0;
   end

   function automatic logic [5:0] exp_pins(input logic [11:0] s, input logic fn,
                                           input logic an, input bit turbo);
      logic [5:0] joy;
      logic [5:0] kp;
      logic [5:0] res;
      joy = 6'h3F;
      if (s[K_UP])           joy[0] = 1'b0;
      if (s[K_RIGHT])        joy[1] = 1'b0;
      if (s[K_DOWN])         joy[2] = 1'b0;
      if (s[K_LEFT])         joy[3] = 1'b0;
      if (s[K_B] || turbo)   joy[5] = 1'b0;
      kp = 6'h3F;
      if (s[K_SEL])          kp[3:0] = 4'h9;
      else if (s[K_START])   kp[3:0] = 4'h6;
      else if (s[K_X])       kp[3:0] = 4'hD;
      else if (s[K_L])       kp[3:0] = 4'h7;
      else if (s[K_R])       kp[3:0] = 4'hC;
      if (s[K_A])            kp[5] = 1'b0;
      res = 6'h3F;
      if (!fn) res = res & joy;
      if (!an) res = res & kp;
      return res;
   endfunction

   function automatic logic [5:0] model_pins();
      return exp_pins(m_snap, strobe_fire_n, strobe_arm_n, TURBO_ON && m_turbo);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the next snapshot; pins must hold steady until it arrives.
   task automatic wait_snap(input string name);
      logic [5:0] p0;
      bit got;
      bit stable;
      got = 1'b0;
      stable = 1'b1;
      p0 = pins_n;
      for (int i = 0; i < 3 * POLL; i++) begin
         tick();
         if (snap_valid) begin
            got = 1'b1;
            break;
         end
         if (pins_n !== p0) stable = 1'b0;
      end
      checks++;
      if (!got || !stable) begin
         failures++;
         $display("FAIL %s_snap got=%0b stable=%0b required 1 1", name, got, stable);
      end
      if (got) begin
         m_snap = pad_stuck ? 12'h000 : pad_btn;
         if (m_snap[K_Y]) begin
            m_turbo = ((m_ny / TURBO_POLLS) % 2) == 0;
            m_ny++;
         end else begin
            m_turbo = 1'b0;
            m_ny = 0;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      int hc;
      int nf;
      int last;
      bit per_ok;
      bit got;
      logic prev;
      rst = 1'b1;
      repeat (5) tick();
      checks++; if (pins_n !== 6'h3F) begin failures++; $display("FAIL rst_pins got=%h want=3f", pins_n); end
      checks++; if (snes_latch !== 1'b0) begin failures++; $display("FAIL rst_latch got=%b want=0", snes_latch); end
      checks++; if (snes_clk !== 1'b1) begin failures++; $display("FAIL rst_sclk got=%b want=1", snes_clk); end
      checks++; if (snap_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", snap_valid); end
      rst = 1'b0;
      m_snap = 12'h000; m_ny = 0; m_turbo = 1'b0;
      n = 0;
      for (int i = 0; i < 2 * POLL; i++) begin
         tick();
         n++;
         if (snes_latch === 1'b1) break;
      end
      checks++; if (n != POLL) begin failures++; $display("FAIL first_latch got=%0d want=%0d", n, POLL); end
      hc = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (snes_latch !== 1'b1) break;
         hc++;
      end
      checks++; if (hc != LATCH) begin failures++; $display("FAIL latch_width got=%0d want=%0d", hc, LATCH); end
      prev = snes_clk; nf = 0; last = 0; per_ok = 1'b1; got = 1'b0;
      for (int t = 0; t < 200; t++) begin
         tick();
         if (prev === 1'b1 && snes_clk === 1'b0) begin
            if (nf > 0 && (t - last) != 2 * HALF) per_ok = 1'b0;
            last = t;
            nf++;
         end
         prev = snes_clk;
         if (snap_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      checks++; if (nf != 16) begin failures++; $display("FAIL sclk_falls got=%0d want=16", nf); end
      checks++; if (!per_ok || !got) begin failures++; $display("FAIL sclk_period period_ok=%0b snap=%0b want 1 1", per_ok, got); end
      m_snap = pad_btn;
      tick();
      checks++; if (snap_valid !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%b want=0", snap_valid); end
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL rst_idle_pins got=%b want=%b", pins_n, model_pins()); end
   endtask

   task automatic test_joystick();
      pad_btn = 12'h000;
      pad_btn[K_UP] = 1'b1;
      pad_btn[K_B]  = 1'b1;
      strobe_fire_n = 1'b0;
      strobe_arm_n  = 1'b1;
      tick();
      wait_snap("joy");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL joy_pins got=%b want=%b", pins_n, model_pins()); end
      strobe_fire_n = 1'b1;
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL joy_release got=%b want=%b", pins_n, model_pins()); end
   endtask

   task automatic test_keypad();
      pad_btn = 12'h000;
      pad_btn[K_START] = 1'b1;
      pad_btn[K_X]     = 1'b1;
      pad_btn[K_A]     = 1'b1;
      strobe_fire_n = 1'b1;
      strobe_arm_n  = 1'b0;
      tick();
      wait_snap("kp");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL kp_hash got=%b want=%b", pins_n, model_pins()); end
      pad_btn[K_START] = 1'b0;
      wait_snap("kp2");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL kp_one got=%b want=%b", pins_n, model_pins()); end
   endtask

   task automatic test_both();
      pad_btn = 12'h000;
      pad_btn[K_RIGHT] = 1'b1;
      pad_btn[K_L]     = 1'b1;
      strobe_fire_n = 1'b0;
      strobe_arm_n  = 1'b0;
      tick();
      wait_snap("both");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL both_pins got=%b want=%b", pins_n, model_pins()); end
   endtask

   task automatic test_disconnect();
      pad_btn = 12'h000;
      pad_btn[K_UP] = 1'b1;
      strobe_fire_n = 1'b0;
      strobe_arm_n  = 1'b1;
      tick();
      wait_snap("disc_pre");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL disc_pre got=%b want=%b", pins_n, model_pins()); end
      pad_stuck = 1'b1;
      wait_snap("disc");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL disc_pins got=%b want=%b", pins_n, model_pins()); end
      pad_stuck = 1'b0;
   endtask

   task automatic test_reset_mid();
      int nf;
      int n;
      bit reached;
      bit saw_snap;
      logic prev;
      pad_btn = 12'h000;
      pad_btn[K_UP] = 1'b1;
      strobe_fire_n = 1'b0;
      strobe_arm_n  = 1'b1;
      tick();
      wait_snap("mid_pre");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL mid_pre got=%b want=%b", pins_n, model_pins()); end
      reached = 1'b0;
      for (int i = 0; i < 2 * POLL; i++) begin
         tick();
         if (snes_latch === 1'b1) break;
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (snes_latch === 1'b0) break;
      end
      prev = snes_clk; nf = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (prev === 1'b1 && snes_clk === 1'b0) nf++;
         prev = snes_clk;
         if (nf == 8) begin
            reached = 1'b1;
            break;
         end
      end
      checks++; if (!reached) begin failures++; $display("FAIL mid_reach got=%0d falls want=8", nf); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_snap = 12'h000; m_ny = 0; m_turbo = 1'b0;
      checks++; if (snes_clk !== 1'b1) begin failures++; $display("FAIL mid_sclk got=%b want=1", snes_clk); end
      checks++; if (snes_latch !== 1'b0) begin failures++; $display("FAIL mid_latch got=%b want=0", snes_latch); end
      checks++; if (pins_n !== 6'h3F) begin failures++; $display("FAIL mid_pins got=%b want=111111", pins_n); end
      n = 0; saw_snap = 1'b0;
      for (int i = 0; i < 2 * POLL; i++) begin
         tick();
         n++;
         if (snap_valid === 1'b1) saw_snap = 1'b1;
         if (snes_latch === 1'b1) break;
      end
      checks++; if (n != POLL || saw_snap) begin failures++; $display("FAIL mid_restart latch_at=%0d snap=%0b want %0d 0", n, saw_snap, POLL); end
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL mid_cleared got=%b want=%b", pins_n, model_pins()); end
      wait_snap("mid_post");
      tick();
      checks++; if (pins_n !== model_pins()) begin failures++; $display("FAIL mid_post got=%b want=%b", pins_n, model_pins()); end
   endtask

   task automatic test_turbo();
      pad_btn = 12'h000;
      pad_btn[K_Y] = 1'b1;
      strobe_fire_n = 1'b0;
      strobe_arm_n  = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         wait_snap("turbo");
         tick();
         checks++;
         if (pins_n !== model_pins()) begin
            failures++;
            $display("FAIL turbo_%0d got=%b want=%b", k, pins_n, model_pins());
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 10; k++) begin
         pad_btn       = 12'($urandom);
         strobe_fire_n = 1'($urandom_range(0, 1));
         strobe_arm_n  = 1'($urandom_range(0, 1));
         tick();
         wait_snap("rand");
         tick();
         checks++;
         if (pins_n !== model_pins()) begin
            failures++;
            $display("FAIL rand_snap_%0d btn=%h got=%b want=%b", k, m_snap, pins_n, model_pins());
         end
         strobe_fire_n = 1'($urandom_range(0, 1));
         strobe_arm_n  = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (pins_n !== model_pins()) begin
            failures++;
            $display("FAIL rand_strobe_%0d f=%b a=%b got=%b want=%b", k, strobe_fire_n, strobe_arm_n, pins_n, model_pins());
         end
      end
   endtask

   initial begin
      test_reset();
      test_joystick();
      test_keypad();
      test_both();
      test_disconnect();
      test_reset_mid();
      test_turbo();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snes_coleco_ctrl.md
Name: snes_coleco_ctrl

Overview:
- Controller front-end feeding the ColecoVision glue block's controller inputs (C1P0-C1P3, C1P5, C1P6).
- Periodically polls an SNES-style serial gamepad (latch/clock/data) and holds a snapshot of its 12 buttons.
- Drives the six active-low controller pins. The pin pattern depends on which common strobe the glue asserts: C1P7 (fire/joystick) or C1P4 (arm/keypad).
- One instance per player.

Parameters:
- LATCH_CYC, 43, clk cycles latch is held high (~12 us at 3.58 MHz).
- HALF_CYC, 21, clk cycles per half period of snes_clk (~6 us).
- POLL_CYC, 59659, clk cycles between poll starts (~60 Hz); must exceed LATCH_CYC+32*HALF_CYC.
- TURBO_POLLS, 4, polls per turbo half-period (used only with TURBO_FIRE_EN).

Ports:
- clk  in  1  system clock (same domain as glue).
- rst  in  1  synchronous, active-high reset.
- snes_latch  out  1  pad latch, active high.
- snes_clk  out  1  pad shift clock, idles high.
- snes_data  in  1  pad serial data, active low (0 = pressed).
- strobe_fire_n  in  1  glue C1P7/C2_FIRE; low selects joystick mode.
- strobe_arm_n  in  1  glue C1P4/C4_ARM; low selects keypad mode.
- pins_n  out  6  {P6,P5,P3,P2,P1,P0} to the glue, active low.
- snap_valid  out  1  one-clk pulse when a new snapshot is committed.

Behaviour:
- Reset (synchronous): state IDLE, poll counter cleared, snes_latch=0, snes_clk=1, pins_n=6'h3F, snap_valid=0, snapshot = all released.
- FSM IDLE -> LATCH -> SHIFT -> DONE -> IDLE.
  - IDLE: counts to POLL_CYC-1. The first poll starts POLL_CYC cycles after rst deasserts.
  - LATCH: snes_latch=1 for LATCH_CYC cycles, then 0.
  - SHIFT: 16 bits. Each bit: sample snes_data on the last cycle of the high half, then drive snes_clk low for HALF_CYC, then high for HALF_CYC. Bit 0 is sampled before the first falling edge. Shift order: B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R, then 4 ID bits.
  - DONE (1 clk): commit the snapshot, pulse snap_valid, return to IDLE. The poll period is measured start-to-start.
- Disconnect: if all 16 sampled bits are 0 (data stuck low), commit an all-released snapshot.
- rst mid-poll: immediate return to the reset state. The partial shift is discarded and the previous snapshot is cleared.
- Joystick pattern (active low):
  - P0=Up, P1=Right, P2=Down, P3=Left, P6=B (left fire), P5=1.
- Keypad pattern:
  - P3..P0 = keypad code, P6=A (right fire), P5=1.
  - Codes: none=F, 1=D, 2=7, 3=C, *=9, #=6.
  - Source buttons, priority high to low: Select(*) > Start(#) > X(1) > L(2) > R(3).
- Strobe combination:
  - Only fire_n low: joystick pattern.
  - Only arm_n low: keypad pattern.
  - Both low: bitwise AND of both patterns (wired-low).
  - Neither low: 6'h3F.
- Timing: pins_n is registered with 1 clk latency from a strobe change or a snapshot commit. It never updates mid-shift; it always reflects the last committed snapshot.

Optional Feature:
- Macro: SNES_COLECO_TURBO_FIRE_EN.
- Defined: a Y button press yields left fire (P6 in joystick mode) that toggles every TURBO_POLLS committed snapshots, ORed with B. The turbo phase counter resets when Y is released and on rst.
- Undefined: Y is ignored. No turbo counter is synthesized.

Decomposition:
- Package coleco_ctrl_pkg:
  - SNES button bit-index localparams.
  - Keypad code constants (KP_NONE, KP_1, KP_2, KP_3, KP_STAR, KP_HASH).
  - FSM state encoding.
- Sub-module snes_pad_reader: the FSM, counters and shift register. Outputs a 12-bit active-high button vector plus snap_valid.
- Top-level: pin mapping, keypad priority encoding, turbo logic.

Test Plan:
- All tests use LATCH_CYC=3, HALF_CYC=2, POLL_CYC=200.
- Reset: hold rst 5 clk, then release -> pins_n=3F, latch=0, snes_clk=1. First latch rise exactly 200 clk after release; latch high exactly 3 clk. 16 falling edges of snes_clk at a 4-clk period.
- Joystick: pad model returns Up+B pressed, fire_n=0, arm_n=1 -> after snap_valid, pins_n=6'b011110. Setting fire_n=1 -> pins_n=3F one clk later.
- Keypad priority: Start+X+A pressed, arm_n=0 -> pins_n = {P6=0, P5=1, code=4'h6}. Releasing Start -> code=4'hD after the next snapshot.
- Both strobes low with Right+L pressed -> pins_n = (joystick 6'b111101) AND (keypad {1,1,4'h7}) = 6'b110101.
- Disconnect and reset mid-op:
  - Data held low during a poll with prior Up pressed -> released snapshot, pins_n=3F in joystick mode.
  - rst asserted at bit 7 of SHIFT -> snes_clk=1, latch=0 next clk; no snap_valid until a full poll after release.
- Turbo (macro defined, TURBO_POLLS=2): Y held with fire_n=0 -> P6 alternates 0,0,1,1,... on successive snap_valid pulses. Macro undefined -> P6 stays 1.
